wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 17 +
 rtl/wb_fifo.sv | 72 +++++++
 rtl/wb_arbiter.sv | 118 +++++++++++
 tb/tb_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared ISA widths, requester indices and the queue entry layout used by the
// writeback arbiter and its per-requester queues.
package wb_arbiter_pkg;

    localparam int unsigned WORD = 32;
    localparam int unsigned REG  = 5;

    localparam int unsigned ALU  = 0;
    localparam int unsigned LOAD = 1;
    localparam int unsigned MDU  = 2;

    typedef struct packed {
        logic [REG-1:0]  rd;
        logic [WORD-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-requester writeback queue: DEPTH entries of {rd, data} with per-entry
// valid/register taps so the arbiter can answer hazard queries.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  wb_entry_t            din,
    output wb_entry_t            dout,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH-1:0]     tap_valid,
    output logic [DEPTH*REG-1:0] tap_reg
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = &valid;
    assign empty   = ~|valid;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // Occupancy lives in per-slot valid bits; pop and push never hit the
    // same slot because push needs a free slot and pop needs a filled one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (do_pop) begin
                valid[rptr] <= 1'b0;
                rptr        <= next_ptr(rptr);
            end
            if (do_push) begin
                valid[wptr] <= 1'b1;
                wptr        <= next_ptr(wptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_comb begin
        tap_valid = valid;
        tap_reg   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            tap_reg[i*REG +: REG] = mem[i].rd;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one queue per requester, round-robin grant into a
// registered register-file write port, plus pending-write hazard queries.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      reqValid,
    output logic [NREQ-1:0]      reqReady,
    input  logic [REG*NREQ-1:0]  reqReg,
    input  logic [WORD*NREQ-1:0] reqData,
    output logic                 regWrite,
    output logic [REG-1:0]       writeReg,
    output logic [WORD-1:0]      writeData,
    input  logic [REG-1:0]       qReg1,
    input  logic [REG-1:0]       qReg2,
    output logic                 qBusy1,
    output logic                 qBusy2
);

    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IW1 = IW + 1;

    logic [NREQ-1:0]      full;
    logic [NREQ-1:0]      empty;
    logic [NREQ-1:0]      grant;
    wb_entry_t            head      [NREQ];
    logic [DEPTH-1:0]     tap_valid [NREQ];
    logic [DEPTH*REG-1:0] tap_reg   [NREQ];

    logic [IW-1:0]  rr;
    logic [IW-1:0]  gsel;
    logic           gany;
    logic [IW:0]    cand;
    logic [REG-1:0] treg;

    assign reqReady = ~full;

    for (genvar g = 0; g < NREQ; g++) begin : g_q
        wb_entry_t din;
        assign din.rd   = reqReg[g*REG +: REG];
        assign din.data = reqData[g*WORD +: WORD];

        wb_fifo #(
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (reqValid[g] & ~full[g]),
            .pop      (grant[g]),
            .din      (din),
            .dout     (head[g]),
            .full     (full[g]),
            .empty    (empty[g]),
            .tap_valid(tap_valid[g]),
            .tap_reg  (tap_reg[g])
        );
    end

    // First non-empty queue scanning upward from rr, wrapping at NREQ.
    always_comb begin
        grant = '0;
        gsel  = '0;
        gany  = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW1'(rr) + IW1'(k);
            if (cand >= IW1'(NREQ)) begin
                cand = cand - IW1'(NREQ);
            end
            if (!gany && !empty[cand[IW-1:0]]) begin
                gany = 1'b1;
                gsel = cand[IW-1:0];
            end
        end
        if (gany) begin
            grant[gsel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr        <= '0;
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else if (gany) begin
            rr        <= (gsel == IW'(NREQ - 1)) ? '0 : gsel + IW'(1);
            regWrite  <= (head[gsel].rd != '0);
            writeReg  <= head[gsel].rd;
            writeData <= head[gsel].data;
        end else begin
            regWrite  <= 1'b0;
        end
    end

    always_comb begin
        qBusy1 = 1'b0;
        qBusy2 = 1'b0;
        treg   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                treg = tap_reg[i][j*REG +: REG];
                if (tap_valid[i][j] && treg == qReg1) qBusy1 = 1'b1;
                if (tap_valid[i][j] && treg == qReg2) qBusy2 = 1'b1;
            end
        end
        if (regWrite && writeReg == qReg1) qBusy1 = 1'b1;
        if (regWrite && writeReg == qReg2) qBusy2 = 1'b1;
        // $zero is never a hazard, even when a reg-0 entry sits in a queue.
        if (qReg1 == '0) qBusy1 = 1'b0;
        if (qReg2 == '0) qBusy2 = 1'b0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model feeding a
// scoreboard, with a negedge monitor comparing every cycle.
module tb_wb_arbiter;

    localparam int NREQ  = 3;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   reqValid;
    logic [NREQ-1:0]   reqReady;
    logic [5*NREQ-1:0] reqReg;
    logic [32*NREQ-1:0] reqData;
    logic              regWrite;
    logic [4:0]        writeReg;
    logic [31:0]       writeData;
    logic [4:0]        qReg1;
    logic [4:0]        qReg2;
    logic              qBusy1;
    logic              qBusy2;

    wb_arbiter #(
        .NREQ (NREQ),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqReg   (reqReg),
        .reqData  (reqData),
        .regWrite (regWrite),
        .writeReg (writeReg),
        .writeData(writeData),
        .qReg1    (qReg1),
        .qReg2    (qReg2),
        .qBusy1   (qBusy1),
        .qBusy2   (qBusy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq [NREQ][$];
    ent_t        sb [$];
    int          m_rr;
    logic        m_rw;
    logic [4:0]  m_reg;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic mbusy(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        for (int i = 0; i < NREQ; i++)
            foreach (mq[i][j])
                if (mq[i][j].rd == q) return 1'b1;
        return m_rw && (m_reg == q);
    endfunction

    function automatic logic [NREQ-1:0] mready();
        logic [NREQ-1:0] r;
        for (int i = 0; i < NREQ; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    // Reference model: per-requester FIFOs, round-robin pick, one write per cycle.
    initial begin
        m_rr = 0; m_rw = 1'b0; m_reg = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NREQ; i++) mq[i].delete();
                sb.delete();
                m_rr = 0; m_rw = 1'b0; m_reg = '0;
            end else begin
                int   pre [NREQ];
                bit   granted;
                ent_t e;
                for (int i = 0; i < NREQ; i++) pre[i] = mq[i].size();
                granted = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_rr + k) % NREQ;
                    if (!granted && mq[i].size() > 0) begin
                        e = mq[i].pop_front();
                        granted = 1'b1;
                        m_rr  = (i + 1) % NREQ;
                        m_rw  = (e.rd != 5'd0);
                        m_reg = e.rd;
                        if (e.rd != 5'd0) sb.push_back(e);
                    end
                end
                if (!granted) m_rw = 1'b0;
                for (int i = 0; i < NREQ; i++) begin
                    if (reqValid[i] && pre[i] < DEPTH) begin
                        e.rd   = reqReg[5*i +: 5];
                        e.data = reqData[32*i +: 32];
                        mq[i].push_back(e);
                    end
                end
            end
        end
    end

    // Monitor: cycle-accurate flags against the model, write contents from the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("reqReady", 32'(reqReady), 32'(mready()));
                chk("regWrite", 32'(regWrite), 32'(m_rw));
                chk("qBusy1", 32'(qBusy1), 32'(mbusy(qReg1)));
                chk("qBusy2", 32'(qBusy2), 32'(mbusy(qReg2)));
                if (regWrite === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_write", 32'(writeReg), 32'h0);
                    end else begin
                        ent_t e;
                        e = sb.pop_front();
                        chk("writeReg", 32'(writeReg), 32'(e.rd));
                        chk("writeData", writeData, e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reqValid = '0;
    endtask

    task automatic offer(input int i, input logic [4:0] rd, input logic [31:0] data);
        reqValid[i]       = 1'b1;
        reqReg[5*i +: 5]  = rd;
        reqData[32*i +: 32] = data;
    endtask

    task automatic reset_checks(input string tag);
        #1;
        chk({tag, "_regWrite"}, 32'(regWrite), 32'h0);
        chk({tag, "_reqReady"}, 32'(reqReady), 32'h7);
        chk({tag, "_qBusy1"}, 32'(qBusy1), 32'h0);
        chk({tag, "_qBusy2"}, 32'(qBusy2), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        reset_checks("rst_async");
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int idx;
        bit acc;
        bit saw_full;

        rst_n = 1'b0; reqValid = '0; reqReg = '0; reqData = '0;
        qReg1 = 5'd5; qReg2 = 5'd0;
        #2;
        reset_checks("por");
        chk("por_writeReg", 32'(writeReg), 32'h0);
        chk("por_writeData", writeData, 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Single ALU write, uncontended.
        offer(0, 5'd5, 32'h12345678);
        tick(); idle();
        repeat (4) tick();

        // Three-way contention from rr=0.
        do_reset();
        offer(0, 5'd1, 32'hA1); offer(1, 5'd2, 32'hB2); offer(2, 5'd3, 32'hC3);
        tick(); idle();
        repeat (5) tick();

        // LOAD back-to-back against a saturating ALU.
        idx = 0; saw_full = 1'b0;
        for (int c = 0; c < 30 && idx < 3; c++) begin
            offer(0, 5'($urandom_range(1, 31)), $urandom);
            offer(1, 5'(20 + idx), 32'h1000 + 32'(idx));
            @(negedge clk);
            acc = reqReady[1];
            if (!reqReady[1]) saw_full = 1'b1;
            tick();
            if (acc) idx++;
        end
        idle();
        chk("load_all_accepted", 32'(idx), 32'd3);
        chk("load_backpressure_seen", 32'(saw_full), 32'd1);
        repeat (10) tick();

        // $zero write from MDU.
        qReg1 = 5'd0; qReg2 = 5'd0;
        offer(2, 5'd0, 32'hDEADBEEF);
        tick(); idle();
        repeat (3) tick();

        // Hazard on reg 9 queued by LOAD.
        qReg1 = 5'd9; qReg2 = 5'd9;
        offer(1, 5'd9, 32'h99);
        tick(); idle();
        repeat (4) tick();

        // Reset with several entries pending.
        qReg1 = 5'd11;
        offer(0, 5'd11, 32'h1); offer(1, 5'd12, 32'h2); offer(2, 5'd13, 32'h3);
        tick();
        offer(0, 5'd14, 32'h4); offer(1, 5'd11, 32'h5);
        tick(); idle();
        do_reset();
        repeat (6) tick();

        // Randomized traffic with small register range to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 99) < 55) offer(i, 5'($urandom_range(0, 15)), $urandom);
                else reqValid[i] = 1'b0;
            end
            qReg1 = 5'($urandom_range(0, 15));
            qReg2 = 5'($urandom_range(0, 15));
            tick();
        end
        idle();
        repeat (12) tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
